// File: rtl/ser2par_32_sync.sv
`default_nettype none
// ============================================================================
// Module   : ser2par_32_sync
// Purpose  : Serial-to-parallel front stage. Collects a serial bit stream into
//            a DATA_W-bit word and presents it to a downstream register bank
//            over a valid/ready handshake. Each completed word is held stable
//            until the consumer takes it. In HOLD, in_ready follows out_ready,
//            so a new word can start on the same edge that the old one leaves.
// Options  : SER2PAR_PARITY_EN - when defined, each word is followed by one
//            even-parity bit. The result is reported on out_perr. When
//            undefined, out_perr is tied low. Both builds have the same ports.
// Revision : 1.0 - initial release
// ============================================================================
module ser2par_32_sync #(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_bit,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_perr,
  output logic [$clog2(DATA_W+1)-1:0]  bit_cnt
);

  localparam int CNT_W = $clog2(DATA_W+1);
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    bit_cnt_q;

  logic [DATA_W-1:0]   shift_d;
  logic [CNT_W-1:0]    cnt_inc_d;
  logic                in_beat;
  logic                out_beat;
  logic                last_bit;

  assign in_beat   = in_valid & in_ready;
  assign out_beat  = out_valid_q & out_ready;
  assign last_bit  = (bit_cnt_q == C_LAST_IDX);
  assign cnt_inc_d = bit_cnt_q + C_CNT_ONE;

  // The shift direction decides where the first received bit ends up.
  // MSB-first shifts left, so the first bit reaches bit DATA_W-1.
  // LSB-first shifts right, so the first bit reaches bit 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_d = {shreg_q[DATA_W-2:0], in_bit};
    end else begin : g_lsb_first
      assign shift_d = {in_bit, shreg_q[DATA_W-1:1]};
    end
  endgenerate

  // in_ready is decoded from state. In HOLD it follows out_ready, so one bit
  // can be accepted on the same edge as the output transfer (no bubble).
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_COLLECT: in_ready = 1'b1;
      ST_PARITY:  in_ready = 1'b1;
      ST_HOLD:    in_ready = out_ready;
      default:    in_ready = 1'b0;
    endcase
  end

`ifdef SER2PAR_PARITY_EN
  logic out_perr_q;

  // Main control FSM for the parity build. A word is published only after
  // its trailing parity bit has been taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      bit_cnt_q   <= '0;
    end else if (clr) begin
      // A flush behaves like reset, except the last published word stays
      // visible on out_data.
      state_q     <= ST_COLLECT;
      shreg_q     <= '0;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (in_beat) begin
            shreg_q   <= shift_d;
            bit_cnt_q <= cnt_inc_d;
            if (last_bit) begin
              state_q <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (in_beat) begin
            // Even parity: the XOR of the word and the parity bit must be 0.
            out_data_q  <= shreg_q;
            out_perr_q  <= (^shreg_q) ^ in_bit;
            out_valid_q <= 1'b1;
            bit_cnt_q   <= '0;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_beat) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_COLLECT;
            if (in_beat) begin
              shreg_q   <= shift_d;
              bit_cnt_q <= C_CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign out_perr = out_perr_q;
`else
  // Main control FSM for the plain build. A word is published on the same
  // edge that takes its last data bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else if (clr) begin
      // A flush behaves like reset, except the last published word stays
      // visible on out_data.
      state_q     <= ST_COLLECT;
      shreg_q     <= '0;
      out_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (in_beat) begin
            shreg_q <= shift_d;
            if (last_bit) begin
              out_data_q  <= shift_d;
              out_valid_q <= 1'b1;
              bit_cnt_q   <= '0;
              state_q     <= ST_HOLD;
            end else begin
              bit_cnt_q <= cnt_inc_d;
            end
          end
        end
        ST_HOLD: begin
          if (out_beat) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_COLLECT;
            if (in_beat) begin
              shreg_q   <= shift_d;
              bit_cnt_q <= C_CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign out_perr = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign bit_cnt   = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ser2par_32_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser2par_32_sync
// Purpose  : Directed, table-driven bench for ser2par_32_sync. Two instances
//            share the same stimulus: one is MSB-first and one is LSB-first.
//            Their outputs are checked against hand-computed words. Build with
//            SER2PAR_PARITY_EN defined to exercise the parity variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser2par_32_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_m, in_ready_l;
  logic [31:0] data_m, data_l;
  logic        valid_m, valid_l;
  logic        perr_m, perr_l;
  logic [5:0]  cnt_m, cnt_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ser2par_32_sync #(.DATA_W(32), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_data(data_m), .out_valid(valid_m),
    .out_ready(out_ready), .out_perr(perr_m), .bit_cnt(cnt_m)
  );

  ser2par_32_sync #(.DATA_W(32), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_data(data_l), .out_valid(valid_l),
    .out_ready(out_ready), .out_perr(perr_l), .bit_cnt(cnt_l)
  );

  typedef struct {
    logic [31:0] seq;    // seq[31] is sent first
    bit          gaps;
    logic [31:0] exp_m;
    logic [31:0] exp_l;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_bit   = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Sends bits seq[31-start] .. seq[31-(stop-1)] in time order.
  // With stop==32 the word completes; in the parity build pbit is sent next.
  task automatic send_seq(input logic [31:0] seq, input bit gaps, input int start,
                          input int stop, input logic pbit);
    for (int k = start; k < stop; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        step();
        chk("stall_cnt", 32'(cnt_m), 32'(k));
      end
      chk("in_ready_collect", 32'(in_ready_m), 32'd1);
      send_bit(seq[31-k]);
      if (k < 31) begin
        chk("bit_cnt_m", 32'(cnt_m), 32'(k + 1));
        chk("bit_cnt_l", 32'(cnt_l), 32'(k + 1));
      end
    end
    if (stop == 32) begin
`ifdef SER2PAR_PARITY_EN
      chk("valid_before_parity", 32'(valid_m), 32'd0);
      chk("in_ready_parity", 32'(in_ready_m), 32'd1);
      send_bit(pbit);
`endif
      chk("valid_after_word", 32'(valid_m), 32'd1);
      chk("cnt_after_word", 32'(cnt_m), 32'd0);
    end
  endtask

  task automatic check_word(input logic [31:0] em, input logic [31:0] el, input logic ep);
    chk("data_msb", data_m, em);
    chk("data_lsb", data_l, el);
    chk("valid_lsb", 32'(valid_l), 32'd1);
    chk("perr_msb", 32'(perr_m), 32'(ep));
    chk("perr_lsb", 32'(perr_l), 32'(ep));
  endtask

  // Upper bound on run time so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [2];
    int beats;

    vecs[0] = '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'hF77DB57B};
    vecs[1] = '{32'h80000000, 1'b1, 32'h80000000, 32'h00000001};
    vecs[2] = '{32'h12345678, 1'b1, 32'h12345678, 32'h1E6A2C48};
    vecs[3] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{32'h00000000, 1'b1, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_data", data_m, 32'd0);
    chk("rst_perr", 32'(perr_m), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready_m), 32'd1);

    // Table-driven words; out_valid must be high for exactly one cycle
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send_seq(vecs[i].seq, vecs[i].gaps, 0, 32, ^vecs[i].seq);
      check_word(vecs[i].exp_m, vecs[i].exp_l, 1'b0);
      step();
      chk("valid_one_cycle", 32'(valid_m), 32'd0);
      chk("cnt_idle", 32'(cnt_m), 32'd0);
    end

    // Back-pressure: word is held for 5 cycles and input is blocked
    out_ready = 1'b0;
    send_seq(32'hCAFEF00D, 1'b0, 0, 32, ^32'hCAFEF00D);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    repeat (5) begin
      step();
      chk("bp_in_ready", 32'(in_ready_m), 32'd0);
      chk("bp_valid", 32'(valid_m), 32'd1);
      chk("bp_data_stable", data_m, 32'hCAFEF00D);
      chk("bp_cnt", 32'(cnt_m), 32'd0);
    end
    out_ready = 1'b1;
    in_bit    = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_release_valid", 32'(valid_m), 32'd0);
    chk("bp_release_cnt", 32'(cnt_m), 32'd1);
    send_seq(32'h80000000, 1'b0, 1, 32, 1'b1);
    check_word(32'h80000000, 32'h00000001, 1'b0);
    step();

    // clr mid-word discards partial bits and keeps out_data
    send_seq(32'hFFFFFFFF, 1'b0, 0, 17, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", 32'(cnt_m), 32'd0);
    chk("clr_valid", 32'(valid_m), 32'd0);
    chk("clr_keeps_data", data_m, 32'h80000000);
    send_seq(32'h12345678, 1'b0, 0, 32, ^32'h12345678);
    check_word(32'h12345678, 32'h1E6A2C48, 1'b0);
    step();

    // Reset mid-word: same as clr, but out_data is cleared
    send_seq(32'hFFFFFFFF, 1'b0, 0, 17, 1'b0);
    rst_n = 1'b0;
    clr   = 1'b1;
    step();
    rst_n = 1'b1;
    clr   = 1'b0;
    chk("rst_mid_cnt", 32'(cnt_m), 32'd0);
    chk("rst_mid_data", data_m, 32'd0);
    send_seq(32'h12345678, 1'b0, 0, 32, ^32'h12345678);
    check_word(32'h12345678, 32'h1E6A2C48, 1'b0);
    step();

    // clr in HOLD drops the word even with out_ready high
    out_ready = 1'b0;
    send_seq(32'hA5A5A5A5, 1'b0, 0, 32, ^32'hA5A5A5A5);
    out_ready = 1'b1;
    clr       = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hold_valid", 32'(valid_m), 32'd0);
    chk("clr_hold_data", data_m, 32'hA5A5A5A5);
    step();
    chk("clr_hold_no_repost", 32'(valid_m), 32'd0);

    // Back-to-back words with in_valid held high
    beats    = 0;
    in_valid = 1'b1;
`ifdef SER2PAR_PARITY_EN
    for (int c = 0; c < 66; c++) begin
`else
    for (int c = 0; c < 64; c++) begin
`endif
      in_bit = (c < 32) ? 1'b1 : 1'b0;
      step();
      if (valid_m) begin
        if (beats < 2) words[beats] = data_m;
        beats++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_beats", 32'(beats), 32'd2);
    chk("b2b_word0", words[0], 32'hFFFFFFFF);
    chk("b2b_word1", words[1], 32'h00000000);
    step();
    chk("b2b_idle_valid", 32'(valid_m), 32'd0);
    chk("b2b_idle_cnt", 32'(cnt_m), 32'd0);

`ifdef SER2PAR_PARITY_EN
    // Even parity: the XOR of the word and the parity bit must be 0.
    send_seq(32'h00000003, 1'b0, 0, 32, 1'b0);
    check_word(32'h00000003, rev32(32'h00000003), 1'b0);
    step();
    send_seq(32'h00000007, 1'b0, 0, 32, 1'b0);
    check_word(32'h00000007, rev32(32'h00000007), 1'b1);
    step();
`else
    chk("perr_tied_low", 32'(perr_m), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ser2par_32_sync.md
Name: ser2par_32_sync

Overview:
- Serial-to-parallel front stage. Collects a serial bit stream into a DATA_W-bit word and presents it to the downstream 32-bit positive-edge D register bank with a valid/ready handshake.
- Holds each completed word stable until the consumer accepts it.
- Provides bit counting, bit-order selection, synchronous flush and back-pressure.

Parameters:
- DATA_W, 32, word width in bits (2..64).
- MSB_FIRST, 1: 1 = first received bit lands in bit DATA_W-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- clr  input  1  synchronous flush: discard the partial word and any held word.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle.
- out_data  output  DATA_W  assembled word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_perr  output  1  parity error flag for out_data. Tied 0 when the optional feature is absent.
- bit_cnt  output  $clog2(DATA_W+1)  number of data bits accepted into the current word.

Interface: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=COLLECT, shift register=0, out_data=0, out_valid=0, out_perr=0, bit_cnt=0. in_ready=1 from the first cycle after reset.
- Input beat: in_valid & in_ready at a rising edge.
- Output beat: out_valid & out_ready at a rising edge.
- All outputs are registered except in_ready, which is decoded from state.
- State COLLECT:
  - in_ready=1.
  - Each input beat shifts in_bit into the shift register per MSB_FIRST and increments bit_cnt.
  - When the beat with bit_cnt==DATA_W-1 is taken:
    - Without parity: out_data <= completed word, out_valid <= 1, bit_cnt <= 0, state <= HOLD.
    - With parity: state <= PARITY instead.
- State PARITY (feature only):
  - in_ready=1.
  - The next input beat is the parity bit.
  - out_perr <= XOR(word, parity bit), so even parity is required.
  - out_valid <= 1, state <= HOLD, bit_cnt <= 0.
- State HOLD:
  - out_valid=1; out_data and out_perr are stable.
  - in_ready = out_ready, giving zero-bubble streaming.
  - On an output beat: if an input beat also occurs, that bit becomes bit 0 of the next word and bit_cnt <= 1. Either way, state <= COLLECT and out_valid <= 0.
  - With no output beat: hold, and accept no input.
- Latency: out_valid rises on the rising edge that captures the last data bit (or the parity bit), i.e. visible the cycle after that beat.
- Throughput: one word per DATA_W cycles (DATA_W+1 with parity) under continuous valid/ready.
- Boundary and priority rules:
  - in_valid=0 stalls with no state change.
  - Gaps between bits are allowed at any position.
  - clr has priority over all beats: same effect as reset, except out_data keeps its value. clr in HOLD drops out_valid even if out_ready=1; that word counts as not transferred.
  - rst_n has priority over clr.
  - Reset or clr mid-word discards all partial bits; the next accepted bit is bit 0 of a new word.
  - bit_cnt never exceeds DATA_W-1 as a visible value in COLLECT; it wraps to 0 on word completion.
  - out_data must not change while out_valid=1.

Optional Feature:
- Macro: SER2PAR_PARITY_EN.
- Defined: PARITY state present; one parity bit follows each word; out_perr driven as above.
- Undefined: no PARITY state; words are exactly DATA_W bits; out_perr constant 0. The port list is identical in both builds.

Test Plan:
- Reset then 32 consecutive beats of 0xDEADBEEF, MSB_FIRST=1, out_ready=1 -> out_valid=1 for exactly one cycle, out_data=0xDEADBEEF, out_perr=0, bit_cnt returns 0.
- MSB_FIRST=0, bits of 0x00000001 sent LSB first with random in_valid gaps -> out_data=0x00000001; bit_cnt increments only on accepted beats.
- Word complete with out_ready=0 for 5 cycles -> in_ready=0, out_data stable for all 5 cycles. Then out_ready=1 together with in_valid=1 and in_bit=1 -> word transferred, bit_cnt=1 next cycle.
- 17 bits accepted, then clr=1 for one cycle, then 32 bits of 0x12345678 -> out_data=0x12345678 with no leftover bits. Repeat using rst_n=0 instead of clr -> same result.
- Back-to-back words 0xFFFFFFFF and 0x00000000 with out_ready=1 and in_valid held high -> exactly 2 output beats in 64 cycles, no dropped bits.
- SER2PAR_PARITY_EN defined:
  - 0x00000003 with parity bit 0 -> out_perr=0.
  - 0x00000007 with parity bit 0 -> out_perr=1.
  - Both cases -> out_valid rises only after the 33rd beat.
